// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and default constants.
package if_pkg;
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_pc_unit.sv
// Program counter: reset value, +4 advance under FSM enable, word-aligned redirect.
module pc_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [29:0] target_word,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4
);
  assign pc_plus_4 = pc + 32'd4;

  // Only the word index is passed in, so a redirect can never misalign the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= {target_word, 2'b00};
    else if (en)       pc <= pc_plus_4;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC ownership, busywait fetch handshake, stall hold buffer, branch flush.
// Optional fetch/bubble counters are built when IF_FETCH_STATS_EN is defined.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_PLUS_4,
  output logic        IF_VALID,
`ifdef IF_FETCH_STATS_EN
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] BUBBLE_COUNT,
`endif
  output logic        FETCH_BUSY
);
  fetch_state_e state, next_state;
  logic        pc_en, ld_fetch, ld_hold, ld_bubble, capture;
  logic [31:0] pc, pc_plus_4;
  logic [31:0] hb_instr, hb_pc_plus_4;

  pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (CLK),
    .rst        (RESET),
    .en         (pc_en),
    .redirect   (BRANCH_TAKEN),
    .target_word(BRANCH_TARGET[31:2]),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4)
  );

  assign IMEM_ADDRESS = pc;
  assign IMEM_READ    = (state == FETCH);
  assign FETCH_BUSY   = IMEM_READ & IMEM_BUSYWAIT;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= BOOT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    ld_fetch   = 1'b0;
    ld_hold    = 1'b0;
    ld_bubble  = 1'b0;
    capture    = 1'b0;
    if (BRANCH_TAKEN) begin
      // Redirect beats stall and busywait; the pending read is simply dropped.
      next_state = REDIRECT;
      ld_bubble  = 1'b1;
    end else begin
      unique case (state)
        BOOT, REDIRECT: next_state = FETCH;
        FETCH: begin
          if (IMEM_BUSYWAIT) begin
            ld_bubble = ~STALL;
          end else if (STALL) begin
            capture    = 1'b1;
            next_state = HOLD;
          end else begin
            ld_fetch = 1'b1;
            pc_en    = 1'b1;
          end
        end
        HOLD: begin
          if (!STALL) begin
            ld_hold    = 1'b1;
            pc_en      = 1'b1;
            next_state = FETCH;
          end
        end
        default: next_state = BOOT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      INSTRUCTION <= NOP_INSTR;
      PC_PLUS_4   <= RESET_PC + 32'd4;
      IF_VALID    <= 1'b0;
    end else if (ld_bubble) begin
      INSTRUCTION <= NOP_INSTR;
      IF_VALID    <= 1'b0;
    end else if (ld_fetch) begin
      INSTRUCTION <= IMEM_READDATA;
      PC_PLUS_4   <= pc_plus_4;
      IF_VALID    <= 1'b1;
    end else if (ld_hold) begin
      INSTRUCTION <= hb_instr;
      PC_PLUS_4   <= hb_pc_plus_4;
      IF_VALID    <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || BRANCH_TAKEN) begin
      hb_instr     <= NOP_INSTR;
      hb_pc_plus_4 <= 32'd0;
    end else if (capture) begin
      hb_instr     <= IMEM_READDATA;
      hb_pc_plus_4 <= pc_plus_4;
    end
  end

`ifdef IF_FETCH_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FETCH_COUNT  <= 32'd0;
      BUBBLE_COUNT <= 32'd0;
    end else begin
      if ((ld_fetch || ld_hold) && FETCH_COUNT != 32'hFFFF_FFFF) FETCH_COUNT <= FETCH_COUNT + 32'd1;
      if (ld_bubble && BUBBLE_COUNT != 32'hFFFF_FFFF)            BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan scenarios plus randomized traffic
// against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0, BRANCH_TAKEN = 1'b0, IMEM_BUSYWAIT = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic [31:0] IMEM_READDATA, IMEM_ADDRESS, INSTRUCTION, PC_PLUS_4;
  logic        IMEM_READ, IF_VALID, FETCH_BUSY;
`ifdef IF_FETCH_STATS_EN
  logic [31:0] FETCH_COUNT, BUBBLE_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .IMEM_ADDRESS(IMEM_ADDRESS), .IMEM_READ(IMEM_READ), .INSTRUCTION(INSTRUCTION),
    .PC_PLUS_4(PC_PLUS_4), .IF_VALID(IF_VALID),
`ifdef IF_FETCH_STATS_EN
    .FETCH_COUNT(FETCH_COUNT), .BUBBLE_COUNT(BUBBLE_COUNT),
`endif
    .FETCH_BUSY(FETCH_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'd100;
      32'h0000_0004: return 32'd200;
      32'h0000_0008: return 32'd300;
      32'h0000_000C: return 32'd400;
      32'hFFFF_FFFC: return 32'd500;
      default:       return (a * 32'h0001_0003) ^ 32'h5A5A_0001;
    endcase
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

  // Model: the stage is either waiting out a no-request cycle (after reset or a branch),
  // sitting on one captured word, or actively requesting the word at m_pc.
  logic [31:0] m_pc, m_instr, m_pp4, m_hword, m_hpp4, m_fc, m_bc;
  logic        m_valid, m_quiet, m_held;

  function automatic logic m_read();
    return !m_quiet && !m_held;
  endfunction

  function automatic logic [98:0] expect_vec();
    return {m_pc, m_read(), m_instr, m_pp4, m_valid, m_read() & IMEM_BUSYWAIT};
  endfunction

  function automatic logic [98:0] actual_vec();
    return {IMEM_ADDRESS, IMEM_READ, INSTRUCTION, PC_PLUS_4, IF_VALID, FETCH_BUSY};
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pp4 = 32'd4; m_valid = 1'b0;
    m_quiet = 1'b1; m_held = 1'b0; m_hword = 32'd0; m_hpp4 = 32'd0;
    m_fc = 32'd0; m_bc = 32'd0;
  endtask

  task automatic model_edge(input logic stall, busy, br, input logic [31:0] tgt);
    if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0;
      m_held = 1'b0; m_quiet = 1'b1; m_bc++;
    end else if (m_quiet) begin
      m_quiet = 1'b0;
    end else if (m_held) begin
      if (!stall) begin
        m_instr = m_hword; m_pp4 = m_hpp4; m_valid = 1'b1; m_pc += 4; m_held = 1'b0; m_fc++;
      end
    end else if (busy) begin
      if (!stall) begin m_instr = NOP; m_valid = 1'b0; m_bc++; end
    end else if (stall) begin
      m_held = 1'b1; m_hword = mem_word(m_pc); m_hpp4 = m_pc + 4;
    end else begin
      m_instr = mem_word(m_pc); m_pp4 = m_pc + 4; m_valid = 1'b1; m_pc += 4; m_fc++;
    end
  endtask

  task automatic step(input logic stall, busy, br, input logic [31:0] tgt);
    STALL = stall; IMEM_BUSYWAIT = busy; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    model_edge(stall, busy, br, tgt);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; model_reset();
    repeat (2) @(posedge CLK); #1;
    checks++;
    if (actual_vec() !== expect_vec() || INSTRUCTION !== NOP || PC_PLUS_4 !== 32'd4 || IF_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_state: got %h want %h", actual_vec(), expect_vec());
    end
    RESET = 1'b0;
    step(0, 0, 0, 0);
    checks++;
    if (IMEM_READ !== 1'b1 || IF_VALID !== 1'b0 || IMEM_ADDRESS !== 32'd0) begin
      errors++; $display("FAIL boot_exit: read=%b valid=%b addr=%h want 1 0 0", IMEM_READ, IF_VALID, IMEM_ADDRESS);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] want_i [3];
    want_i[0] = 32'd100; want_i[1] = 32'd200; want_i[2] = 32'd300;
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 2), 0, 0);
      checks++;
      if (actual_vec() !== expect_vec()) begin
        errors++; $display("FAIL zero_wait[%0d]: got %h want %h", i, actual_vec(), expect_vec());
      end
      if (i < 2) begin
        checks++;
        if (INSTRUCTION !== want_i[i] || PC_PLUS_4 !== 32'(4 * (i + 1)) || IF_VALID !== 1'b1) begin
          errors++; $display("FAIL zero_wait_val[%0d]: got %0d/%0d want %0d/%0d", i, INSTRUCTION, PC_PLUS_4, want_i[i], 4 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_busywait();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (actual_vec() !== expect_vec() || IMEM_ADDRESS !== 32'd8 || INSTRUCTION !== NOP || IF_VALID !== 1'b0) begin
        errors++; $display("FAIL busywait[%0d]: got %h want %h", i, actual_vec(), expect_vec());
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (actual_vec() !== expect_vec() || INSTRUCTION !== 32'd300 || PC_PLUS_4 !== 32'd12) begin
      errors++; $display("FAIL busywait_done: got %0d/%0d want 300/12", INSTRUCTION, PC_PLUS_4);
    end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (actual_vec() !== expect_vec() || IMEM_READ !== 1'b0 || INSTRUCTION !== 32'd300 || PC_PLUS_4 !== 32'd12) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, actual_vec(), expect_vec());
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (actual_vec() !== expect_vec() || INSTRUCTION !== 32'd400 || PC_PLUS_4 !== 32'd16 || IF_VALID !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %0d/%0d want 400/16", INSTRUCTION, PC_PLUS_4);
    end
    step(0, 0, 0, 0);
    checks++;
    if (actual_vec() !== expect_vec() || PC_PLUS_4 !== 32'd20) begin
      errors++; $display("FAIL stall_resume: got %h want %h", actual_vec(), expect_vec());
    end
  endtask

  task automatic test_branch();
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0043);
    checks++;
    if (actual_vec() !== expect_vec() || IMEM_ADDRESS !== 32'h40 || IMEM_READ !== 1'b0 || IF_VALID !== 1'b0) begin
      errors++; $display("FAIL branch_redirect: got %h want %h", actual_vec(), expect_vec());
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (actual_vec() !== expect_vec() || PC_PLUS_4 !== 32'h44 || IF_VALID !== 1'b1) begin
      errors++; $display("FAIL branch_fetch: got pp4=%h want 44", PC_PLUS_4);
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (actual_vec() !== expect_vec() || INSTRUCTION !== 32'd500 || PC_PLUS_4 !== 32'd0 || IMEM_ADDRESS !== 32'd0) begin
      errors++; $display("FAIL pc_wrap: got %h want %h", actual_vec(), expect_vec());
    end
  endtask

  task automatic test_reset_mid_hold();
    RESET = 1'b1; #2; RESET = 1'b0; model_reset();
    @(posedge CLK); #1;
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if (actual_vec() !== expect_vec() || IMEM_READ !== 1'b0 || INSTRUCTION !== NOP || PC_PLUS_4 !== 32'd4) begin
      errors++; $display("FAIL reset_async: got %h want %h", actual_vec(), expect_vec());
    end
    @(posedge CLK); #1 RESET = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (actual_vec() !== expect_vec() || INSTRUCTION !== 32'd100 || PC_PLUS_4 !== 32'd4) begin
      errors++; $display("FAIL reset_hold_drop: got %0d/%0d want 100/4", INSTRUCTION, PC_PLUS_4);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, tgt);
      checks++;
      if (actual_vec() !== expect_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, actual_vec(), expect_vec());
      end
`ifdef IF_FETCH_STATS_EN
      checks++;
      if (FETCH_COUNT !== m_fc || BUBBLE_COUNT !== m_bc) begin
        errors++; $display("FAIL stats[%0d]: got %0d/%0d want %0d/%0d", i, FETCH_COUNT, BUBBLE_COUNT, m_fc, m_bc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_busywait();
    test_stall_hold();
    test_branch();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
